ula_operand_loader: RTL and testbench
=====================================

ULA_OPERAND_LOADER -- requirements
Module: ula_operand_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter OPW, default 3, opcode width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port data_in  input  WIDTH  shared load bus carrying A, then B, then opcode.
REQ-006 SHALL have port load  input  1  one-cycle strobe: data_in valid this cycle.
REQ-007 SHALL have port cancel  input  1  abort current sequence.
REQ-008 SHALL have port A  output  WIDTH  registered operand A to the logic unit.
REQ-009 SHALL have port B  output  WIDTH  registered operand B to the logic unit.
REQ-010 SHALL have port Opcode  output  OPW  registered opcode to the logic unit.
REQ-011 SHALL have port out_valid  output  1  A/B/Opcode complete and stable.
REQ-012 SHALL have port out_ready  input  1  downstream consumed the operand set.
REQ-013 SHALL have port op_err  output  1  one-cycle pulse: opcode word rejected.
REQ-014 SHALL have port txn_count  output  8  count of completed handshakes.

Function
REQ-015 SHALL implement FSM states GET_A, GET_B, GET_OP, HOLD; reset state GET_A.
REQ-016 GET_A: load=1 -> A<=data_in, go GET_B; else stay.
REQ-017 GET_B: load=1 -> B<=data_in, go GET_OP; else stay.
REQ-018 GET_OP: load=1 with data_in[WIDTH-1:OPW]==0 -> Opcode<=data_in[OPW-1:0], go HOLD.
REQ-019 GET_OP: load=1 with any data_in[WIDTH-1:OPW] bit set -> Opcode unchanged, op_err=1 next cycle only, stay GET_OP.
REQ-020 out_valid SHALL be 1 exactly while in HOLD; asserted the cycle after the accepted opcode load (latency 1).
REQ-021 HOLD: out_ready=1 -> handshake; go GET_A, txn_count+1 (8-bit, 255 wraps to 0).
REQ-022 HOLD: load SHALL be ignored; A, B, Opcode SHALL not change while out_valid=1.
REQ-023 cancel=1 in any state SHALL go GET_A next cycle, with priority over load and out_ready; no handshake counted, op_err not pulsed.
REQ-024 A, B, Opcode SHALL retain last captured values after handshake or cancel (not cleared).
REQ-025 out_ready in GET_A/GET_B/GET_OP SHALL be ignored.
REQ-026 op_err SHALL never be asserted in two consecutive cycles unless two consecutive invalid loads occur.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state GET_A, A=0, B=0, Opcode=0, out_valid=0, op_err=0, txn_count=0.
REQ-028 Reset SHALL override cancel, load, out_ready; reset mid-sequence discards partial operands.
REQ-029 No output SHALL change asynchronously with rst_n.

Structure
REQ-030 Shared package ula_pkg SHALL hold the FSM state enum, OPW constant, and opcode encodings (AND 00x, OR 01x, XOR 10x, NOT 11x; bit0 = invert result).
REQ-031 Block SHALL be a single module with no sub-module; Opcode output width SHALL match the logic unit's opcode input.

Verification
REQ-032 Load 0x3C, 0x0F, 0x02 on three cycles -> next cycle out_valid=1, A=0x3C, B=0x0F, Opcode=3'b010; out_ready=1 -> GET_A, txn_count=1.
REQ-033 In GET_OP load 0x09 -> op_err pulses one cycle, out_valid stays 0; then load 0x05 -> Opcode=3'b101, out_valid=1.
REQ-034 In HOLD with out_ready=0 for 5 cycles and load=1 data 0xFF each cycle -> A/B/Opcode unchanged, out_valid held 1.
REQ-035 cancel=1 in GET_OP together with load -> GET_A, out_valid=0, txn_count unchanged; cancel with out_ready in HOLD -> no count.
REQ-036 256 complete handshakes -> txn_count returns to 0x00; rst_n=0 in GET_B -> all outputs 0, next load captures A.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg
//   Shared definitions for the logic-unit operand loader and the logic unit
//   it feeds: loader FSM state encoding, default opcode width and the opcode
//   encodings.
//
//   Opcode layout (3 bits): [2:1] selects the operation family, [0] inverts
//   the result (AND/NAND, OR/NOR, XOR/XNOR, NOT/buffer).
package ula_pkg;

  // Opcode width shared by the loader's Opcode output and the logic unit's
  // opcode input; both sides must agree.
  localparam int ULA_OPW = 3;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    HOLD   = 2'd3
  } ula_state_e;

  // Operation family in opcode bits [2:1].
  typedef enum logic [1:0] {
    FAM_AND = 2'b00,
    FAM_OR  = 2'b01,
    FAM_XOR = 2'b10,
    FAM_NOT = 2'b11
  } ula_family_e;

  localparam int OPC_INV_BIT = 0;

  localparam logic [ULA_OPW-1:0] OPC_AND  = 3'b000;
  localparam logic [ULA_OPW-1:0] OPC_NAND = 3'b001;
  localparam logic [ULA_OPW-1:0] OPC_OR   = 3'b010;
  localparam logic [ULA_OPW-1:0] OPC_NOR  = 3'b011;
  localparam logic [ULA_OPW-1:0] OPC_XOR  = 3'b100;
  localparam logic [ULA_OPW-1:0] OPC_XNOR = 3'b101;
  localparam logic [ULA_OPW-1:0] OPC_NOT  = 3'b110;
  localparam logic [ULA_OPW-1:0] OPC_BUF  = 3'b111;

  // Operation family of an opcode word.
  function automatic ula_family_e opc_family(input logic [ULA_OPW-1:0] opc);
    return ula_family_e'(opc[2:1]);
  endfunction

  // True when the opcode asks for the inverted result.
  function automatic logic opc_inverts(input logic [ULA_OPW-1:0] opc);
    return opc[OPC_INV_BIT];
  endfunction

endpackage

// File: rtl/ula_operand_loader.sv
// ula_operand_loader
//   Collects operand A, operand B and an opcode from a shared load bus, one
//   word per load strobe, and presents them to the logic unit as a stable,
//   registered set until the consumer takes it.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   GET_A  | waiting for operand A word
//   GET_B  | waiting for operand B word
//   GET_OP | waiting for opcode word; words with upper bits set are rejected
//   HOLD   | operand set valid, waiting for out_ready
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   data_in   : shared load bus (A, then B, then opcode)
//   load      : one-cycle strobe, data_in valid
//   cancel    : abort the sequence, back to GET_A
//   A, B      : registered operands
//   Opcode    : registered opcode
//   out_valid : operand set complete (high exactly in HOLD)
//   out_ready : consumer took the operand set
//   op_err    : one-cycle pulse after a rejected opcode word
//   txn_count : completed handshakes, wraps at 256
module ula_operand_loader
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = ULA_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             cancel,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OPW-1:0]   Opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             op_err,
  output logic [7:0]       txn_count
);

  ula_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             valid_q;
  logic             err_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;

  // An opcode word is legal only when every bit above the opcode field is 0.
  logic opc_word_ok;
  assign opc_word_ok = (data_in[WIDTH-1:OPW] == '0);

  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // op_err is a pulse; only a rejected opcode in this cycle re-arms it.
      err_q <= 1'b0;
      if (cancel) begin
        // Captured operands are kept; only the sequence position resets.
        state_q <= GET_A;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          GET_A: begin
            if (load) begin
              a_q     <= data_in;
              state_q <= GET_B;
            end
          end
          GET_B: begin
            if (load) begin
              b_q     <= data_in;
              state_q <= GET_OP;
            end
          end
          GET_OP: begin
            if (load) begin
              if (opc_word_ok) begin
                op_q    <= data_in[OPW-1:0];
                state_q <= HOLD;
                valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            // load is ignored here so the presented set stays frozen.
            if (out_ready) begin
              state_q <= GET_A;
              valid_q <= 1'b0;
              cnt_q   <= cnt_d;
            end
          end
          default: begin
            state_q <= GET_A;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Opcode    = op_q;
  assign out_valid = valid_q;
  assign op_err    = err_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_ula_operand_loader.sv
module tb_ula_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       load;
  logic       cancel;
  logic       out_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] Opcode;
  logic       out_valid;
  logic       op_err;
  logic [7:0] txn_count;

  always #5 clk = ~clk;

  ula_operand_loader #(.WIDTH(8), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load      (load),
    .cancel    (cancel),
    .A         (A),
    .B         (B),
    .Opcode    (Opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_err    (op_err),
    .txn_count (txn_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words_taken counts how many of the three words of the
  // current set have been accepted (3 = set presented).
  int   words_taken;
  int   m_a, m_b, m_op, m_cnt;
  bit   m_err;

  task automatic model_reset();
    words_taken = 0;
    m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int d;
    d = int'(data_in);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (cancel) begin
      words_taken = 0;
    end else if (words_taken == 3) begin
      if (out_ready) begin
        words_taken = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
    end else if (load) begin
      if (words_taken == 0) begin
        m_a = d; words_taken = 1;
      end else if (words_taken == 1) begin
        m_b = d; words_taken = 2;
      end else if (d < 8) begin
        m_op = d; words_taken = 3;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".A"},         int'(A),         m_a);
    chk({tag, ".B"},         int'(B),         m_b);
    chk({tag, ".Opcode"},    int'(Opcode),    m_op);
    chk({tag, ".out_valid"}, int'(out_valid), (words_taken == 3) ? 1 : 0);
    chk({tag, ".op_err"},    int'(op_err),    int'(m_err));
    chk({tag, ".txn_count"}, int'(txn_count), m_cnt);
  endtask

  task automatic cyc(input string tag, input logic r, input logic l,
                     input logic [7:0] d, input logic c, input logic rdy);
    rst_n = r; load = l; data_in = d; cancel = c; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rl, rc, rr, rs;
    model_reset();
    rst_n = 1'b0; load = 1'b0; data_in = 8'h00; cancel = 1'b0; out_ready = 1'b0;

    // Reset with every other input active: reset must win.
    cyc("reset", 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1);
    cyc("reset2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset.valid_lit", int'(out_valid), 0);

    // Basic sequence 0x3C, 0x0F, 0x02.
    cyc("seqA", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("seqA.no_valid", int'(out_valid), 0);
    cyc("seqB", 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1);
    cyc("seqOp", 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    chk("seq.A_lit", int'(A), 8'h3C);
    chk("seq.B_lit", int'(B), 8'h0F);
    chk("seq.Op_lit", int'(Opcode), 3'b010);
    chk("seq.valid_lit", int'(out_valid), 1);
    cyc("seqHs", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("seqHs.cnt_lit", int'(txn_count), 1);
    chk("seqHs.A_kept", int'(A), 8'h3C);

    // Rejected opcode word, then a good one.
    cyc("errA", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc("errB", 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    cyc("errBad", 1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    chk("errBad.pulse_lit", int'(op_err), 1);
    chk("errBad.op_kept", int'(Opcode), 3'b010);
    cyc("errIdle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("errIdle.pulse_gone", int'(op_err), 0);
    cyc("errBad2", 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
    cyc("errBad3", 1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
    cyc("errGood", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
    chk("errGood.op_lit", int'(Opcode), 3'b101);
    chk("errGood.valid_lit", int'(out_valid), 1);

    // Hold: loads of 0xFF ignored, out_ready low.
    for (int i = 0; i < 5; i++) cyc("hold", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("hold.A_lit", int'(A), 8'h11);
    chk("hold.valid_lit", int'(out_valid), 1);

    // Cancel together with out_ready in HOLD: no count.
    cyc("cancelHold", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("cancelHold.cnt_lit", int'(txn_count), 1);
    // Cancel in GET_OP together with a load.
    cyc("cA", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    cyc("cB", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    cyc("cancelOp", 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
    chk("cancelOp.op_kept", int'(Opcode), 3'b101);
    cyc("cRestart", 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    chk("cRestart.A_lit", int'(A), 8'h66);

    // Reset mid-sequence (in GET_B), next load captures A.
    cyc("rstMid", 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("rstMid.A_lit", int'(A), 0);
    cyc("rstNext", 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("rstNext.A_lit", int'(A), 8'h99);
    chk("rstNext.B_lit", int'(B), 0);
    cyc("rstIdle", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // 256 handshakes wrap the counter back to its starting value.
    for (int i = 0; i < 256; i++) begin
      cyc("wrapA", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc("wrapB", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc("wrapOp", 1'b1, 1'b1, 8'($urandom_range(0, 7)), 1'b0, 1'b0);
      cyc("wrapHs", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("wrap.cnt_lit", int'(txn_count), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      rl = ($urandom_range(0, 9) < 6);
      rc = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 9) < 4);
      rs = ($urandom_range(0, 99) != 0);
      cyc("rand", rs, rl, rd, rc, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
